usb_tx_encoder: RTL and testbench

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

---
 rtl/usb_tx_if.sv | 24 ++
 rtl/usb_tx_encoder.sv | 190 +++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_if.sv
// Byte-source / line-output bundle between a packet producer and the USB
// transmit encoder.
interface usb_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_last;
    logic       get_byte;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_start, tx_data, tx_data_valid, tx_last,
        input  get_byte, dplus_out, dminus_out, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_start, tx_data, tx_data_valid, tx_last,
        output get_byte, dplus_out, dminus_out, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB full-speed style transmit encoder: SYNC, NRZI data with bit stuffing,
// and EOP, at 8 clk cycles per bit.
module usb_tx_encoder (
    input  logic     clk,
    input  logic     rst,
    usb_tx_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       last_q, last_d;
    logic       lvl_q, lvl_d;
    logic       dp_q, dp_d;
    logic       dm_q, dm_d;
    logic       busy_q, busy_d;
    logic       gb_q, gb_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic boundary;
    logic do_emit, emit_bit, do_adv, do_load, go_eop;

    assign boundary = (cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == IDLE) ? 3'd0 : cnt_q + 3'd1;
        ones_d    = ones_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        last_d    = last_q;
        lvl_d     = lvl_q;
        dp_d      = dp_q;
        dm_d      = dm_q;
        busy_d    = busy_q;
        gb_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        do_emit   = 1'b0;
        emit_bit  = 1'b0;
        do_adv    = 1'b0;
        do_load   = 1'b0;
        go_eop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    state_d   = SYNC;
                    cnt_d     = 3'd0;
                    bit_idx_d = 3'd0;
                    busy_d    = 1'b1;
                    do_emit   = 1'b1;
                    emit_bit  = 1'b0;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (bit_idx_q == 3'd7) begin
                        do_load = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        do_emit   = 1'b1;
                        emit_bit  = (bit_idx_q == 3'd6);
                    end
                end
            end
            DATA: begin
                // Six ones already on the line: insert a stuffed 0 and hold position.
                if (boundary) begin
                    if (ones_q == 3'd6) begin
                        state_d  = STUFF;
                        do_emit  = 1'b1;
                        emit_bit = 1'b0;
                    end else begin
                        do_adv = 1'b1;
                    end
                end
            end
            STUFF: begin
                if (boundary) do_adv = 1'b1;
            end
            EOP_SE0: begin
                if (boundary) begin
                    if (bit_idx_q == 3'd1) begin
                        state_d = EOP_J;
                        lvl_d   = 1'b1;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
                    end else begin
                        bit_idx_d = 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (boundary) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_adv) begin
            state_d = DATA;
            if (bit_idx_q == 3'd7) begin
                if (last_q) go_eop  = 1'b1;
                else        do_load = 1'b1;
            end else begin
                bit_idx_d = bit_idx_q + 3'd1;
                shift_d   = {1'b0, shift_q[7:1]};
                do_emit   = 1'b1;
                emit_bit  = shift_q[1];
            end
        end

        if (do_load) begin
            if (bus.tx_data_valid) begin
                shift_d   = bus.tx_data;
                last_d    = bus.tx_last;
                gb_d      = 1'b1;
                bit_idx_d = 3'd0;
                state_d   = DATA;
                do_emit   = 1'b1;
                emit_bit  = bus.tx_data[0];
            end else begin
                err_d  = 1'b1;
                go_eop = 1'b1;
            end
        end

        if (go_eop) begin
            state_d   = EOP_SE0;
            bit_idx_d = 3'd0;
            dp_d      = 1'b0;
            dm_d      = 1'b0;
        end

        // NRZI: a 0 toggles the line, a 1 holds it and extends the run of ones.
        if (do_emit) begin
            lvl_d  = emit_bit ? lvl_q : ~lvl_q;
            ones_d = emit_bit ? ones_q + 3'd1 : 3'd0;
            dp_d   = lvl_d;
            dm_d   = ~lvl_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            ones_q    <= 3'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            last_q    <= 1'b0;
            lvl_q     <= 1'b1;
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
            busy_q    <= 1'b0;
            gb_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ones_q    <= ones_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            last_q    <= last_d;
            lvl_q     <= lvl_d;
            dp_q      <= dp_d;
            dm_q      <= dm_d;
            busy_q    <= busy_d;
            gb_q      <= gb_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.get_byte   = gb_q;
    assign bus.dplus_out  = dp_q;
    assign bus.dminus_out = dm_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_done    = done_q;
    assign bus.tx_error   = err_q;
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: a bit-stream model (SYNC + stuffed NRZI + EOP)
// predicts every output on every cycle of each directed packet.
module tb_usb_tx_encoder;
    localparam logic [1:0] LJ = 2'b10;
    localparam logic [1:0] LK = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_tx_if bus();

    usb_tx_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0]   sym_q[$];
    int           load_q[$];
    int           err_bit;
    bit           m_lvl;
    int           m_ones;
    logic [7:0]   pkt[$];
    int           underrun;

    int           done_c;
    int           err_c;
    int           gb_c[$];
    logic [31:0]  packed_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic m_emit(input bit b);
        if (!b) begin
            m_lvl  = !m_lvl;
            m_ones = 0;
        end else begin
            m_ones++;
        end
        sym_q.push_back(m_lvl ? LJ : LK);
        if (m_ones == 6) begin
            m_lvl  = !m_lvl;
            m_ones = 0;
            sym_q.push_back(m_lvl ? LJ : LK);
        end
    endtask

    task automatic build();
        logic [7:0] b;
        sym_q.delete();
        load_q.delete();
        err_bit = -1;
        m_lvl   = 1'b1;
        m_ones  = 0;
        for (int i = 0; i < 8; i++) m_emit(i == 7);
        for (int k = 0; k < pkt.size(); k++) begin
            if (k == underrun) begin
                err_bit = sym_q.size();
                break;
            end
            load_q.push_back(sym_q.size());
            b = pkt[k];
            for (int i = 0; i < 8; i++) m_emit(b[i]);
        end
        sym_q.push_back(LSE0);
        sym_q.push_back(LSE0);
        sym_q.push_back(LJ);
    endtask

    function automatic bit is_load(input int bidx);
        for (int i = 0; i < load_q.size(); i++)
            if (load_q[i] == bidx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic pack_syms(input int from, input int n, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], sym_q[from + i] == LJ};
    endtask

    // Caller must be at a negedge; the start edge is the next posedge.
    task automatic run_packet(input int abort_c, input bit poke);
        int L;
        int k;
        logic [1:0] s;
        logic [5:0] exp_v;
        logic [5:0] act_v;
        build();
        L = sym_q.size();
        done_c = -1;
        err_c  = -1;
        gb_c.delete();
        k = 0;
        bus.tx_start      = 1'b1;
        bus.tx_data       = pkt[0];
        bus.tx_last       = (pkt.size() == 1);
        bus.tx_data_valid = (underrun != 0);
        @(posedge clk);
        for (int c = 0; c <= 8 * L + 1; c++) begin
            @(negedge clk);
            bus.tx_start = poke && (c == 100 || c == 8 * L - 1);
            if (c == abort_c) break;
            s = (c < 8 * L) ? sym_q[c / 8] : LJ;
            exp_v = {s, c < 8 * L, (c < 8 * L) && (c % 8 == 0) && is_load(c / 8),
                     c == 8 * L, (err_bit >= 0) && (c == 8 * err_bit)};
            act_v = {bus.dplus_out, bus.dminus_out, bus.tx_busy, bus.get_byte,
                     bus.tx_done, bus.tx_error};
            chk($sformatf("cycle%0d dp,dm,busy,gb,done,err", c), {26'd0, act_v}, {26'd0, exp_v});
            if (bus.get_byte) begin
                gb_c.push_back(c);
                k++;
                if (k < pkt.size()) begin
                    bus.tx_data       = pkt[k];
                    bus.tx_last       = (k == pkt.size() - 1);
                    bus.tx_data_valid = (k != underrun);
                end
            end
            if (bus.tx_done)  done_c = c;
            if (bus.tx_error) err_c  = c;
        end
        bus.tx_start = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        bus.tx_start      = 1'b0;
        bus.tx_data       = 8'h00;
        bus.tx_data_valid = 1'b0;
        bus.tx_last       = 1'b0;
        underrun          = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {26'd0, bus.dplus_out, bus.dminus_out, bus.tx_busy, bus.get_byte,
                            bus.tx_done, bus.tx_error}, 32'b10_0000);
        rst = 1'b0;
        @(negedge clk);

        // Single 0x00: SYNC KJKJKJKK then eight toggles starting from K.
        pkt = '{8'h00};
        underrun = -1;
        build();
        pack_syms(0, 16, packed_v);
        chk("model_0x00_syms", packed_v, 32'h54AA);
        run_packet(-1, 1'b0);
        chk("done_0x00", done_c, 152);
        chk("gb_count_0x00", gb_c.size(), 1);
        chk("gb_at_0x00", gb_c[0], 64);
        @(negedge clk);

        // Single 0xFF: five ones hold K, stuff to J, three ones hold J.
        pkt = '{8'hFF};
        build();
        pack_syms(8, 9, packed_v);
        chk("model_0xFF_syms", packed_v, 32'h00F);
        run_packet(-1, 1'b0);
        chk("done_0xFF", done_c, 160);
        @(negedge clk);

        // Three bytes, with stray tx_start mid-packet and on the done edge.
        pkt = '{8'hA5, 8'h3C, 8'h81};
        run_packet(-1, 1'b1);
        chk("gb_count_3b", gb_c.size(), 3);
        chk("gb_gap1_3b", gb_c[1] - gb_c[0], 64);
        chk("gb_gap2_3b", gb_c[2] - gb_c[1], 64);
        chk("done_3b", done_c, 280);
        chk("no_err_3b", err_c, -1);
        @(negedge clk);

        // Underrun on the second byte.
        pkt = '{8'h12, 8'h34};
        underrun = 1;
        run_packet(-1, 1'b0);
        chk("err_at_underrun", err_c, 128);
        chk("done_underrun", done_c, 152);
        chk("gb_count_underrun", gb_c.size(), 1);
        underrun = -1;
        @(negedge clk);

        // Stuff bit after a byte's last bit delays the next load.
        pkt = '{8'hFC, 8'hFF};
        run_packet(-1, 1'b0);
        chk("gb_gap_stuffed", gb_c[1] - gb_c[0], 72);
        chk("done_stuffed", done_c, 232);
        @(negedge clk);

        // Stuff bit owed after the final data bit precedes EOP.
        pkt = '{8'hFC};
        run_packet(-1, 1'b0);
        chk("done_stuff_eop", done_c, 160);
        @(negedge clk);

        // Reset during the third data bit, then an immediate new packet.
        pkt = '{8'h55};
        run_packet(8 * 10 + 3, 1'b0);
        #2 rst = 1'b1;
        #1 chk("abort_idle", {26'd0, bus.dplus_out, bus.dminus_out, bus.tx_busy, bus.get_byte,
                              bus.tx_done, bus.tx_error}, 32'b10_0000);
        @(negedge clk);
        rst = 1'b0;
        pkt = '{8'hFF};
        run_packet(-1, 1'b0);
        chk("done_after_reset", done_c, 160);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
